// File: rtl/axi_lite_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_cfg_pkg
//  Purpose  : Shared types and constants for the AXI4-Lite configuration
//             sequencer: bus widths, AXI response codes and FSM encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package axi_lite_cfg_pkg;

  localparam int unsigned AXI_LITE_AW = 32;
  localparam int unsigned AXI_LITE_DW = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_ENC_INIT_WR  = 3'd0;
  localparam logic [2:0] ST_ENC_INIT_B   = 3'd1;
  localparam logic [2:0] ST_ENC_CMD_IDLE = 3'd2;
  localparam logic [2:0] ST_ENC_WR       = 3'd3;
  localparam logic [2:0] ST_ENC_WR_B     = 3'd4;
  localparam logic [2:0] ST_ENC_RD       = 3'd5;
  localparam logic [2:0] ST_ENC_RD_R     = 3'd6;
  localparam logic [2:0] ST_ENC_RSP      = 3'd7;

  typedef enum logic [2:0] {
    ST_INIT_WR  = ST_ENC_INIT_WR,
    ST_INIT_B   = ST_ENC_INIT_B,
    ST_CMD_IDLE = ST_ENC_CMD_IDLE,
    ST_WR       = ST_ENC_WR,
    ST_WR_B     = ST_ENC_WR_B,
    ST_RD       = ST_ENC_RD,
    ST_RD_R     = ST_ENC_RD_R,
    ST_RSP      = ST_ENC_RSP
  } state_e;

endpackage : axi_lite_cfg_pkg
`default_nettype wire

// File: rtl/axi_lite_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_cfg_sequencer
//  Purpose  : AXI4-Lite master for the TIEOFF_M_AXI_CTRL_0 control port.
//             After reset it writes a parameterised (addr,data) table to the
//             slave exactly once, then serves single read/write commands from
//             a valid/ready command port and returns data plus RESP.
//  Ports    : aclk/aresetn        clock, async active-low reset
//             cmd_*               command request (valid/ready, write, addr,
//                                 wdata)
//             rsp_*               response (valid/ready, rdata, resp)
//             init_done/init_err  sticky init-sequence status
//             TIEOFF_M_AXI_CTRL_0_* AXI4-Lite master channels (no WSTRB/PROT)
//  Revision : 1.0  initial release
// ============================================================================
module axi_lite_cfg_sequencer
  import axi_lite_cfg_pkg::*;
#(
  parameter int unsigned INIT_DEPTH = 4,
  parameter logic [32*((INIT_DEPTH > 0) ? INIT_DEPTH : 1)-1:0] INIT_ADDR = '0,
  parameter logic [32*((INIT_DEPTH > 0) ? INIT_DEPTH : 1)-1:0] INIT_DATA = '0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  // command port
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [AXI_LITE_AW-1:0] cmd_addr,
  input  logic [AXI_LITE_DW-1:0] cmd_wdata,
  // response port
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [AXI_LITE_DW-1:0] rsp_rdata,
  output logic [1:0]             rsp_resp,
  // status
  output logic                   init_done,
  output logic                   init_err,
  // AXI4-Lite master
  output logic [AXI_LITE_AW-1:0] TIEOFF_M_AXI_CTRL_0_awaddr,
  output logic                   TIEOFF_M_AXI_CTRL_0_awvalid,
  input  logic                   TIEOFF_M_AXI_CTRL_0_awready,
  output logic [AXI_LITE_DW-1:0] TIEOFF_M_AXI_CTRL_0_wdata,
  output logic                   TIEOFF_M_AXI_CTRL_0_wvalid,
  input  logic                   TIEOFF_M_AXI_CTRL_0_wready,
  input  logic [1:0]             TIEOFF_M_AXI_CTRL_0_bresp,
  input  logic                   TIEOFF_M_AXI_CTRL_0_bvalid,
  output logic                   TIEOFF_M_AXI_CTRL_0_bready,
  output logic [AXI_LITE_AW-1:0] TIEOFF_M_AXI_CTRL_0_araddr,
  output logic                   TIEOFF_M_AXI_CTRL_0_arvalid,
  input  logic                   TIEOFF_M_AXI_CTRL_0_arready,
  input  logic [AXI_LITE_DW-1:0] TIEOFF_M_AXI_CTRL_0_rdata,
  input  logic [1:0]             TIEOFF_M_AXI_CTRL_0_rresp,
  input  logic                   TIEOFF_M_AXI_CTRL_0_rvalid,
  output logic                   TIEOFF_M_AXI_CTRL_0_rready
);

  localparam int unsigned    IDX_W    = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = (INIT_DEPTH > 0) ? IDX_W'(INIT_DEPTH - 1) : '0;

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   aw_done_q;
  logic                   w_done_q;
  logic                   awvalid_q;
  logic                   wvalid_q;
  logic                   arvalid_q;
  logic                   bready_q;
  logic                   rready_q;
  logic [AXI_LITE_AW-1:0] awaddr_q;
  logic [AXI_LITE_DW-1:0] wdata_q;
  logic [AXI_LITE_AW-1:0] araddr_q;
  logic                   rsp_valid_q;
  logic [AXI_LITE_DW-1:0] rsp_rdata_q;
  logic [1:0]             rsp_resp_q;
  logic                   init_done_q;
  logic                   init_err_q;

  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_aw_fin;
  logic                   w_w_fin;
  logic [AXI_LITE_AW-1:0] w_init_addr;
  logic [AXI_LITE_DW-1:0] w_init_data;

  // Table entries are 32 bits wide, so {idx,5'b0} is the bit offset of entry idx.
  assign w_init_addr = INIT_ADDR[{idx_q, 5'b0} +: AXI_LITE_AW];
  assign w_init_data = INIT_DATA[{idx_q, 5'b0} +: AXI_LITE_DW];

  assign w_aw_hs  = awvalid_q & TIEOFF_M_AXI_CTRL_0_awready;
  assign w_w_hs   = wvalid_q  & TIEOFF_M_AXI_CTRL_0_wready;
  // A channel is finished if it completed earlier or is completing right now.
  assign w_aw_fin = aw_done_q | w_aw_hs;
  assign w_w_fin  = w_done_q  | w_w_hs;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= (INIT_DEPTH == 0) ? ST_CMD_IDLE : ST_INIT_WR;
      idx_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= AXI_RESP_OKAY;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT_WR, ST_WR: begin
          // AW and W retire independently; each valid drops on its own handshake.
          if (w_aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end else if (state_q == ST_INIT_WR && !awvalid_q && !aw_done_q) begin
            awvalid_q <= 1'b1;
            awaddr_q  <= w_init_addr;
          end
          if (w_w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end else if (state_q == ST_INIT_WR && !wvalid_q && !w_done_q) begin
            wvalid_q <= 1'b1;
            wdata_q  <= w_init_data;
          end
          if (w_aw_fin && w_w_fin) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= (state_q == ST_INIT_WR) ? ST_INIT_B : ST_WR_B;
          end
        end

        ST_INIT_B: begin
          if (TIEOFF_M_AXI_CTRL_0_bvalid) begin
            bready_q <= 1'b0;
            if (TIEOFF_M_AXI_CTRL_0_bresp != AXI_RESP_OKAY) begin
              init_err_q <= 1'b1;
            end
            if (idx_q == LAST_IDX) begin
              init_done_q <= 1'b1;
              state_q     <= ST_CMD_IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_INIT_WR;
            end
          end
        end

        ST_CMD_IDLE: begin
          // Only reachable with init_done low when the table is empty.
          if (!init_done_q) begin
            init_done_q <= 1'b1;
          end else if (cmd_valid) begin
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD;
            end
          end
        end

        ST_WR_B: begin
          if (TIEOFF_M_AXI_CTRL_0_bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= TIEOFF_M_AXI_CTRL_0_bresp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end

        ST_RD: begin
          if (TIEOFF_M_AXI_CTRL_0_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_R;
          end
        end

        ST_RD_R: begin
          if (TIEOFF_M_AXI_CTRL_0_rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= TIEOFF_M_AXI_CTRL_0_rdata;
            rsp_resp_q  <= TIEOFF_M_AXI_CTRL_0_rresp;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_CMD_IDLE;
          end
        end

        default: state_q <= ST_CMD_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_CMD_IDLE) && init_done_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign init_done = init_done_q;
  assign init_err  = init_err_q;

  assign TIEOFF_M_AXI_CTRL_0_awaddr  = awaddr_q;
  assign TIEOFF_M_AXI_CTRL_0_awvalid = awvalid_q;
  assign TIEOFF_M_AXI_CTRL_0_wdata   = wdata_q;
  assign TIEOFF_M_AXI_CTRL_0_wvalid  = wvalid_q;
  assign TIEOFF_M_AXI_CTRL_0_bready  = bready_q;
  assign TIEOFF_M_AXI_CTRL_0_araddr  = araddr_q;
  assign TIEOFF_M_AXI_CTRL_0_arvalid = arvalid_q;
  assign TIEOFF_M_AXI_CTRL_0_rready  = rready_q;

endmodule : axi_lite_cfg_sequencer
`default_nettype wire

// File: tb/tb_axi_lite_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_cfg_sequencer
//  Purpose  : Self-checking bench for axi_lite_cfg_sequencer with a behavioural
//             AXI4-Lite slave; expected slave writes and command responses are
//             queued by the stimulus and checked by a separate monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_lite_cfg_sequencer;

  localparam logic [95:0] TB_INIT_ADDR = {32'h0000_0008, 32'h0000_0004, 32'h0000_0000};
  localparam logic [95:0] TB_INIT_DATA = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        init_done, init_err;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  axi_lite_cfg_sequencer #(
    .INIT_DEPTH(3),
    .INIT_ADDR (TB_INIT_ADDR),
    .INIT_DATA (TB_INIT_DATA)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .init_done(init_done), .init_err(init_err),
    .TIEOFF_M_AXI_CTRL_0_awaddr(m_awaddr), .TIEOFF_M_AXI_CTRL_0_awvalid(m_awvalid),
    .TIEOFF_M_AXI_CTRL_0_awready(m_awready),
    .TIEOFF_M_AXI_CTRL_0_wdata(m_wdata), .TIEOFF_M_AXI_CTRL_0_wvalid(m_wvalid),
    .TIEOFF_M_AXI_CTRL_0_wready(m_wready),
    .TIEOFF_M_AXI_CTRL_0_bresp(m_bresp), .TIEOFF_M_AXI_CTRL_0_bvalid(m_bvalid),
    .TIEOFF_M_AXI_CTRL_0_bready(m_bready),
    .TIEOFF_M_AXI_CTRL_0_araddr(m_araddr), .TIEOFF_M_AXI_CTRL_0_arvalid(m_arvalid),
    .TIEOFF_M_AXI_CTRL_0_arready(m_arready),
    .TIEOFF_M_AXI_CTRL_0_rdata(m_rdata), .TIEOFF_M_AXI_CTRL_0_rresp(m_rresp),
    .TIEOFF_M_AXI_CTRL_0_rvalid(m_rvalid), .TIEOFF_M_AXI_CTRL_0_rready(m_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- scoreboard state ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [33:0] rsp_q[$];   // {rdata, resp}
  logic [63:0] wr_q[$];    // {addr, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  int          wdelay   = 0;       // W accept delay after AW, in cycles
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic        ar_stall = 1'b0;
  localparam logic [31:0] RD_ERR_ADDR = 32'h0000_BAD0;

  logic [31:0] mem [0:255];
  logic        s_aw_have, s_w_have, s_bvalid, s_rvalid;
  logic [31:0] s_aw_addr, s_w_data, s_rdata;
  logic [1:0]  s_bresp, s_rresp;
  int          s_wcnt;
  int          aw_cnt = 0;
  int          b_cnt  = 0;
  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [31:0] wr_addr_c, wr_data_c;

  assign m_awready = !s_aw_have && !s_bvalid;
  assign m_wready  = !s_w_have && !s_bvalid && (wdelay == 0 || (s_aw_have && s_wcnt >= wdelay));
  assign m_bvalid  = s_bvalid;
  assign m_bresp   = s_bresp;
  assign m_arready = !s_rvalid && !ar_stall;
  assign m_rvalid  = s_rvalid;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;

  assign aw_hs     = m_awvalid && m_awready;
  assign w_hs      = m_wvalid && m_wready;
  assign ar_hs     = m_arvalid && m_arready;
  assign wr_fire   = (s_aw_have || aw_hs) && (s_w_have || w_hs);
  assign wr_addr_c = s_aw_have ? s_aw_addr : m_awaddr;
  assign wr_data_c = s_w_have ? s_w_data : m_wdata;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_aw_have <= 1'b0; s_w_have <= 1'b0; s_aw_addr <= '0; s_w_data <= '0;
      s_wcnt <= 0; s_bvalid <= 1'b0; s_bresp <= 2'b00;
      s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= 2'b00;
    end else begin
      if (aw_hs) aw_cnt <= aw_cnt + 1;
      if (wr_fire) begin
        mem[wr_addr_c[9:2]] <= wr_data_c;
        s_bvalid  <= 1'b1;
        s_bresp   <= (err_en && wr_addr_c == err_addr) ? 2'b10 : 2'b00;
        s_aw_have <= 1'b0;
        s_w_have  <= 1'b0;
        s_wcnt    <= 0;
      end else begin
        if (aw_hs) begin s_aw_have <= 1'b1; s_aw_addr <= m_awaddr; end
        if (w_hs)  begin s_w_have  <= 1'b1; s_w_data  <= m_wdata;  end
        if (s_aw_have && !s_w_have) s_wcnt <= s_wcnt + 1;
      end
      if (s_bvalid && m_bready) begin s_bvalid <= 1'b0; b_cnt <= b_cnt + 1; end
      if (ar_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= (m_araddr == RD_ERR_ADDR) ? 32'h0 : mem[m_araddr[9:2]];
        s_rresp  <= (m_araddr == RD_ERR_ADDR) ? 2'b11 : 2'b00;
      end else if (s_rvalid && m_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        p_hold = 1'b0;
  logic [31:0] p_rdata;
  logic [1:0]  p_resp;

  always @(negedge aclk) begin
    if (!aresetn) begin
      p_hold = 1'b0;
    end else begin
      if (p_hold) check("rsp_stable", {31'h0, rsp_valid, rsp_resp, rsp_rdata}, {31'h0, 1'b1, p_resp, p_rdata});
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) check("unexpected_rsp", {31'h0, rsp_valid}, 64'h0);
        else check("rsp_data_resp", {30'h0, rsp_rdata, rsp_resp}, {30'h0, rsp_q.pop_front()});
      end
      p_hold  = rsp_valid && !rsp_ready;
      p_rdata = rsp_rdata;
      p_resp  = rsp_resp;
      if (wr_fire) begin
        if (wr_q.size() == 0) check("unexpected_write", {wr_addr_c, wr_data_c}, 64'h0);
        else check("slave_write", {wr_addr_c, wr_data_c}, wr_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_init();
    wr_q.push_back({32'h0000_0000, 32'hAAAA_0001});
    wr_q.push_back({32'h0000_0004, 32'hBBBB_0002});
    wr_q.push_back({32'h0000_0008, 32'hCCCC_0003});
  endtask

  task automatic check_reset_outputs(input string name);
    logic [138:0] v;
    v = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, init_done, init_err,
         m_awaddr, m_wdata, m_araddr, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready};
    check(name, {63'h0, |v}, 64'h0);
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic [1:0] exp_resp);
    int n;
    rsp_q.push_back({exp_rd, exp_resp});
    if (wr) wr_q.push_back({addr, wd});
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    forever begin
      @(negedge aclk);
      if (cmd_ready) break;
      if (!init_done) check("ready_during_init", {63'h0, cmd_ready}, 64'h0);
      n++;
      if (n > 200) break;
    end
    check("cmd_ready", {63'h0, cmd_ready}, 64'h1);
    check("accept_after_init", {63'h0, init_done}, 64'h1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check("drain", 64'(rsp_q.size() + wr_q.size()), 64'h0);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check("init_done", {63'h0, init_done}, 64'h1);
  endtask

  task automatic measure_lat(input string name);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!rsp_valid && n < 20);
    check(name, 64'(n), 64'd3);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int aw0, b0, n;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset_outputs");
    push_init();
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Command requested while init is still running: waits, then runs once.
    do_cmd(1'b1, 32'h20, 32'h5555_AAAA, 32'h0, 2'b00);
    drain();
    check("init_err_clean", {63'h0, init_err}, 64'h0);

    // Init table landed in slave memory.
    do_cmd(1'b0, 32'h4, 32'h0, 32'hBBBB_0002, 2'b00); drain();
    do_cmd(1'b0, 32'h8, 32'h0, 32'hCCCC_0003, 2'b00); drain();

    // Minimum latency with a zero-wait slave.
    do_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 2'b00);
    measure_lat("wr_latency"); drain();
    do_cmd(1'b0, 32'h20, 32'h0, 32'h5555_AAAA, 2'b00);
    measure_lat("rd_latency"); drain();

    // Response back-pressure: held stable for 5 cycles.
    rsp_ready = 1'b0;
    do_cmd(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge aclk); n++; end
    check("rsp_valid_seen", {63'h0, rsp_valid}, 64'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check("rsp_valid_held", {63'h0, rsp_valid}, 64'h1);
    end
    @(posedge aclk); #1;
    rsp_ready = 1'b1;
    drain();

    // W accepted well after AW: exactly one AW and one B.
    wdelay = 4;
    aw0 = aw_cnt; b0 = b_cnt;
    do_cmd(1'b1, 32'h30, 32'h1234_5678, 32'h0, 2'b00);
    drain();
    check("aw_count", 64'(aw_cnt - aw0), 64'd1);
    check("b_count", 64'(b_cnt - b0), 64'd1);
    wdelay = 0;
    do_cmd(1'b0, 32'h30, 32'h0, 32'h1234_5678, 2'b00); drain();

    // Error responses are reported, not retried.
    err_en = 1'b1; err_addr = 32'h40;
    do_cmd(1'b1, 32'h40, 32'h0000_0040, 32'h0, 2'b10); drain();
    do_cmd(1'b0, RD_ERR_ADDR, 32'h0, 32'h0, 2'b11); drain();

    // SLVERR on init entry 1: sticky error, remaining entries still written.
    err_addr = 32'h4;
    @(posedge aclk); #1;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    push_init();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    wait_init();
    check("init_err_set", {63'h0, init_err}, 64'h1);
    drain();
    err_en = 1'b0;

    // Reset while a read address is outstanding: everything clears, init replays.
    ar_stall = 1'b1;
    do_cmd(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    @(negedge aclk);
    check("arvalid_pending", {63'h0, m_arvalid}, 64'h1);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_read");
    rsp_q.delete();
    ar_stall = 1'b0;
    repeat (2) @(negedge aclk);
    push_init();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    wait_init();
    check("init_err_after_replay", {63'h0, init_err}, 64'h0);
    drain();
    do_cmd(1'b0, 32'h4, 32'h0, 32'hBBBB_0002, 2'b00); drain();

    repeat (3) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_axi_lite_cfg_sequencer
`default_nettype wire
